// File: rtl/rd_port_arbiter_pkg.sv
// rd_port_arbiter_pkg
//  Shared types for the read-port arbiter slice.
//  addr_t / data_t : memory read address and read data words
//  arb_idx_t       : requester index, stored as a tag per issued read
//  rr_next()       : round-robin successor of a granted index
package rd_port_arbiter_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int NUM_REQ_MAX = 16;

  typedef logic [ADDR_WIDTH-1:0]          addr_t;
  typedef logic [DATA_WIDTH-1:0]          data_t;
  typedef logic [$clog2(NUM_REQ_MAX)-1:0] arb_idx_t;

  // Index after gnt, wrapping at num_req (which need not be a power of 2).
  function automatic arb_idx_t rr_next(input arb_idx_t gnt, input int num_req);
    if (int'(gnt) >= num_req - 1) return '0;
    return gnt + 1'b1;
  endfunction

endpackage

// File: rtl/rd_port_arbiter_fifo.sv
// rd_port_arbiter_fifo
//  Generic synchronous FIFO, used as the in-order tag queue of the arbiter.
//  Head element is presented combinationally (show-ahead).
//  Ports:
//   clk_i, arst_ni      clock, async active-low reset
//   elem_in_*           write side (valid/ready handshake)
//   elem_out_*          read side  (valid/ready handshake)
//  PIPELINED=1 lets a full FIFO accept a write in a cycle it is also popped.
module rd_port_arbiter_fifo #(
  parameter int ELEM_WIDTH = 1,
  parameter int FIFO_SIZE  = 4,
  parameter bit PIPELINED  = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [ELEM_WIDTH-1:0] elem_in_i,
  input  logic                  elem_in_valid_i,
  output logic                  elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0] elem_out_o,
  output logic                  elem_out_valid_o,
  input  logic                  elem_out_ready_i
);

  localparam int PW = $clog2(FIFO_SIZE);

  logic [ELEM_WIDTH-1:0] r_mem [FIFO_SIZE];
  // One extra wrap bit on each pointer distinguishes full from empty.
  logic [PW:0]           r_wr_ptr;
  logic [PW:0]           r_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_empty          = (r_wr_ptr == r_rd_ptr);
  assign w_full           = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                            (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign elem_in_ready_o  = ~w_full | (PIPELINED & elem_out_ready_i);
  assign elem_out_valid_o = ~w_empty;
  assign elem_out_o       = r_mem[r_rd_ptr[PW-1:0]];
  assign w_push           = elem_in_valid_i & elem_in_ready_o;
  assign w_pop            = elem_out_valid_o & elem_out_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= elem_in_i;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rd_port_arbiter.sv
// rd_port_arbiter
//  Shares one memory read port between NUM_REQ requesters. Addresses are granted
//  round-robin; each granted index is queued as a tag so in-order read data can
//  be steered back to the requester that issued it.
//  Ports:
//   clk_i, arst_ni                   clock, async active-low reset
//   req_addr_i/valid_i/ready_o       per-requester address channel
//   req_data_o, req_data_valid_o     broadcast data, one-hot valid
//   mem_addr_o/valid_o/ready_i       address channel to memory
//   mem_data_i, mem_data_valid_i     memory read data (no backpressure)
//   outstanding_o                    reads issued and not yet answered
//   spurious_o                       data beat arrived with no tag queued
module rd_port_arbiter
  import rd_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  addr_t                                req_addr_i [NUM_REQ],
  input  logic [NUM_REQ-1:0]                   req_addr_valid_i,
  output logic [NUM_REQ-1:0]                   req_addr_ready_o,
  output data_t                                req_data_o,
  output logic [NUM_REQ-1:0]                   req_data_valid_o,
  output addr_t                                mem_addr_o,
  output logic                                 mem_addr_valid_o,
  input  logic                                 mem_addr_ready_i,
  input  data_t                                mem_data_i,
  input  logic                                 mem_data_valid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 spurious_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_idx_t           r_rr_ptr;
  arb_idx_t           r_gnt_q;
  logic               r_lock;
  logic [CNT_W-1:0]   r_count;

  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pick;
  arb_idx_t           w_rr_gnt;
  arb_idx_t           w_gnt;
  arb_idx_t           w_head;
  logic               w_gated;
  logic               w_hs;
  logic               w_pop;
  logic               w_tag_in_ready;
  logic               w_tag_valid;

  // Requesters at or above rr_ptr take priority; if none of them is valid,
  // fall back to the lowest valid index (the wrap-around part of the search).
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_masked[gi] = req_addr_valid_i[gi] & (gi >= int'(r_rr_ptr));
    end
  endgenerate

  assign w_pick = (|w_masked) ? w_masked : req_addr_valid_i;

  always_comb begin
    w_rr_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_pick[i]) w_rr_gnt = arb_idx_t'(i);
    end
  end

  // A stalled address holds its grant so the memory sees a stable request.
  assign w_gnt   = r_lock ? r_gnt_q : w_rr_gnt;
  // Gating looks at the registered count: a pop this cycle frees a slot next cycle.
  assign w_gated = (r_count == CNT_W'(MAX_OUTSTANDING)) | ~w_tag_in_ready;

  // arst_ni qualifies the combinational outputs so nothing is asserted in reset.
  assign mem_addr_valid_o = arst_ni & ~w_gated & (r_lock | (|req_addr_valid_i));
  assign w_hs             = mem_addr_valid_o & mem_addr_ready_i;

  always_comb begin
    mem_addr_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == arb_idx_t'(i)) mem_addr_o = req_addr_i[i];
    end
  end

  assign w_pop      = arst_ni & mem_data_valid_i & w_tag_valid;
  assign spurious_o = arst_ni & mem_data_valid_i & ~w_tag_valid;
  assign req_data_o = w_pop ? mem_data_i : '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign req_addr_ready_o[gi] = w_hs  & (w_gnt  == arb_idx_t'(gi));
      assign req_data_valid_o[gi] = w_pop & (w_head == arb_idx_t'(gi));
    end
  endgenerate

  rd_port_arbiter_fifo #(
    .ELEM_WIDTH ($bits(arb_idx_t)),
    .FIFO_SIZE  (MAX_OUTSTANDING),
    .PIPELINED  (1'b0)
  ) u_tag_fifo (
    .clk_i            (clk_i),
    .arst_ni          (arst_ni),
    .elem_in_i        (w_gnt),
    .elem_in_valid_i  (w_hs),
    .elem_in_ready_o  (w_tag_in_ready),
    .elem_out_o       (w_head),
    .elem_out_valid_o (w_tag_valid),
    .elem_out_ready_i (w_pop)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_rr_ptr <= '0;
      r_gnt_q  <= '0;
      r_lock   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_hs) begin
        r_rr_ptr <= rr_next(w_gnt, NUM_REQ);
        r_lock   <= 1'b0;
      end else if (mem_addr_valid_o) begin
        r_lock   <= 1'b1;
        r_gnt_q  <= w_gnt;
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign outstanding_o = r_count;

endmodule

// File: tb/tb_rd_port_arbiter.sv
module tb_rd_port_arbiter;
  import rd_port_arbiter_pkg::*;

  logic        clk;
  logic        arst_n;
  addr_t       req_addr [2];
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  data_t       req_data;
  logic [1:0]  req_dvalid;
  addr_t       mem_addr;
  logic        mem_avalid;
  logic        mem_aready;
  data_t       mem_data;
  logic        mem_dvalid;
  logic [2:0]  outstanding;
  logic        spurious;

  int n_vec = 0;
  int n_err = 0;

  rd_port_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4)) dut (
    .clk_i            (clk),
    .arst_ni          (arst_n),
    .req_addr_i       (req_addr),
    .req_addr_valid_i (req_valid),
    .req_addr_ready_o (req_ready),
    .req_data_o       (req_data),
    .req_data_valid_o (req_dvalid),
    .mem_addr_o       (mem_addr),
    .mem_addr_valid_o (mem_avalid),
    .mem_addr_ready_i (mem_aready),
    .mem_data_i       (mem_data),
    .mem_data_valid_i (mem_dvalid),
    .outstanding_o    (outstanding),
    .spurious_o       (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 2'b00;
    mem_aready = 1'b0;
    mem_dvalid = 1'b0;
    mem_data   = '0;
  endtask

  task automatic drain(input int n);
    req_valid  = 2'b00;
    mem_dvalid = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_data = data_t'(32'h100 + i);
      tick();
    end
    mem_dvalid = 1'b0;
  endtask

  task automatic test_reset();
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    req_valid = 2'b11; mem_aready = 1'b1; mem_dvalid = 1'b1; mem_data = 32'hDEAD;
    arst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_vec++; if (mem_avalid !== 1'b0) begin n_err++; $display("FAIL reset_avalid got %b exp 0", mem_avalid); end
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    n_vec++; if (req_dvalid !== 2'b00) begin n_err++; $display("FAIL reset_dvalid got %b exp 00", req_dvalid); end
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    n_vec++; if (req_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", req_data); end
    tick();
    idle_inputs();
    arst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_d;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    req_valid = 2'b11; mem_aready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      $display("rr cycle %0d addr %h ready %b outstanding %0d", k, mem_addr, req_ready, outstanding);
      n_vec++; if (mem_addr !== ((k % 2 == 0) ? 32'h10 : 32'h20)) begin n_err++; $display("FAIL rr_addr cyc%0d got %h exp %h", k, mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20); end
      n_vec++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL rr_ready cyc%0d got %b", k, req_ready); end
      n_vec++; if (outstanding !== 3'(k)) begin n_err++; $display("FAIL rr_count cyc%0d got %0d exp %0d", k, outstanding, k); end
      tick();
    end
    @(negedge clk);
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL rr_full_count got %0d exp 4", outstanding); end
    n_vec++; if (mem_avalid !== 1'b0) begin n_err++; $display("FAIL rr_full_avalid got %b exp 0", mem_avalid); end
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rr_full_ready got %b exp 00", req_ready); end
    tick();
    // Responses come back in issue order: req0, req1, req0, req1.
    req_valid = 2'b00; mem_dvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_data = data_t'(32'hC0 + k);
      exp_d = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      $display("rr response %0d dvalid %b data %h", k, req_dvalid, req_data);
      n_vec++; if (req_dvalid !== exp_d) begin n_err++; $display("FAIL rr_resp_dvalid beat%0d got %b exp %b", k, req_dvalid, exp_d); end
      n_vec++; if (req_data !== data_t'(32'hC0 + k)) begin n_err++; $display("FAIL rr_resp_data beat%0d got %h exp %h", k, req_data, 32'hC0 + k); end
      tick();
    end
    mem_dvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rr_drained got %0d exp 0", outstanding); end
    tick();
  endtask

  task automatic test_lock();
    // One req0 read first so rr_ptr points at req1; the lock must override it.
    req_valid = 2'b01; mem_aready = 1'b1;
    tick();
    drain(1);
    req_valid = 2'b01; mem_aready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) req_valid = 2'b11;
      @(negedge clk);
      $display("lock cycle %0d addr %h avalid %b", k, mem_addr, mem_avalid);
      n_vec++; if (mem_addr !== 32'h10 || mem_avalid !== 1'b1) begin n_err++; $display("FAIL lock_hold cyc%0d got addr %h valid %b exp 10/1", k, mem_addr, mem_avalid); end
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL lock_ready cyc%0d got %b exp 00", k, req_ready); end
      tick();
    end
    mem_aready = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_addr !== 32'h10 || req_ready !== 2'b01) begin n_err++; $display("FAIL lock_release got addr %h ready %b exp 10/01", mem_addr, req_ready); end
    tick();
    @(negedge clk);
    n_vec++; if (mem_addr !== 32'h20 || req_ready !== 2'b10) begin n_err++; $display("FAIL lock_next got addr %h ready %b exp 20/10", mem_addr, req_ready); end
    tick();
    drain(2);
  endtask

  task automatic test_routing();
    mem_aready = 1'b1;
    req_addr[1] = 32'h20; req_valid = 2'b10;
    @(negedge clk);
    n_vec++; if (mem_addr !== 32'h20 || req_ready !== 2'b10) begin n_err++; $display("FAIL route_issue1 got addr %h ready %b", mem_addr, req_ready); end
    tick();
    req_addr[0] = 32'h30; req_valid = 2'b01;
    @(negedge clk);
    n_vec++; if (mem_addr !== 32'h30 || req_ready !== 2'b01) begin n_err++; $display("FAIL route_issue0 got addr %h ready %b", mem_addr, req_ready); end
    tick();
    req_valid = 2'b00; mem_dvalid = 1'b1; mem_data = 32'hAA;
    @(negedge clk);
    $display("route beat0 dvalid %b data %h", req_dvalid, req_data);
    n_vec++; if (req_dvalid !== 2'b10 || req_data !== 32'hAA) begin n_err++; $display("FAIL route_beat0 got %b/%h exp 10/aa", req_dvalid, req_data); end
    tick();
    mem_data = 32'hBB;
    @(negedge clk);
    $display("route beat1 dvalid %b data %h", req_dvalid, req_data);
    n_vec++; if (req_dvalid !== 2'b01 || req_data !== 32'hBB) begin n_err++; $display("FAIL route_beat1 got %b/%h exp 01/bb", req_dvalid, req_data); end
    tick();
    mem_dvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL route_drained got %0d exp 0", outstanding); end
    tick();
  endtask

  task automatic test_simultaneous();
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    req_valid = 2'b11; mem_aready = 1'b1;
    for (int k = 0; k < 4; k++) tick();   // grants req1, req0, req1, req0
    mem_dvalid = 1'b1; mem_data = 32'h55;
    @(negedge clk);
    $display("sim full+beat avalid %b dvalid %b count %0d", mem_avalid, req_dvalid, outstanding);
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL sim_full_count got %0d exp 4", outstanding); end
    n_vec++; if (mem_avalid !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL sim_gated got valid %b ready %b exp 0/00", mem_avalid, req_ready); end
    n_vec++; if (req_dvalid !== 2'b10 || req_data !== 32'h55) begin n_err++; $display("FAIL sim_beat got %b/%h exp 10/55", req_dvalid, req_data); end
    tick();
    mem_dvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL sim_after_pop got %0d exp 3", outstanding); end
    n_vec++; if (mem_avalid !== 1'b1 || mem_addr !== 32'h20 || req_ready !== 2'b10) begin n_err++; $display("FAIL sim_regrant got valid %b addr %h ready %b exp 1/20/10", mem_avalid, mem_addr, req_ready); end
    tick();
    @(negedge clk);
    n_vec++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL sim_refull got %0d exp 4", outstanding); end
    tick();
    drain(4);
  endtask

  task automatic test_spurious();
    mem_dvalid = 1'b1; mem_data = 32'h77;
    @(negedge clk);
    n_vec++; if (spurious !== 1'b1 || req_dvalid !== 2'b00) begin n_err++; $display("FAIL spur_empty got spur %b dvalid %b exp 1/00", spurious, req_dvalid); end
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL spur_count got %0d exp 0", outstanding); end
    tick();
    mem_dvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL spur_pulse_width got %b exp 0", spurious); end
    tick();
    req_valid = 2'b11; mem_aready = 1'b1;
    tick(); tick();
    idle_inputs();
    @(negedge clk);
    n_vec++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL spur_pre_reset got %0d exp 2", outstanding); end
    arst_n = 1'b0;
    #1;
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL spur_async_reset got %0d exp 0", outstanding); end
    tick();
    arst_n = 1'b1;
    tick();
    mem_dvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mem_data = data_t'(32'hE0 + k);
      @(negedge clk);
      $display("post-reset beat %0d spurious %b dvalid %b", k, spurious, req_dvalid);
      n_vec++; if (spurious !== 1'b1 || req_dvalid !== 2'b00) begin n_err++; $display("FAIL spur_after_reset beat%0d got spur %b dvalid %b exp 1/00", k, spurious, req_dvalid); end
      tick();
    end
    mem_dvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL spur_final_count got %0d exp 0", outstanding); end
  endtask

  initial begin
    arst_n = 1'b0;
    req_addr[0] = '0; req_addr[1] = '0;
    idle_inputs();
    #1;
    test_reset();
    test_round_robin();
    test_lock();
    test_routing();
    test_simultaneous();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
